// File: rtl/count_sequence_monitor_if.sv
// count_sequence_monitor_if
//   Bundle between an observed count bus and the sequence monitor.
//   master: the side presenting samples (drives sample_valid/count_in, reads status)
//   slave : the monitor (reads samples, drives registered status and pulses)
//   Signals:
//     sample_valid      - count_in is sampled this cycle
//     count_in          - observed counter value
//     locked, direction - lock status and recovered count direction (1 = up)
//     step_pulse, wrap_pulse, dir_change_pulse, restart_pulse, error_pulse
//                       - one-cycle event flags
//     error_count       - saturating tally of illegal jumps
interface count_sequence_monitor_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) ();
  logic             sample_valid;
  logic [WIDTH-1:0] count_in;
  logic             locked;
  logic             direction;
  logic             step_pulse;
  logic             wrap_pulse;
  logic             dir_change_pulse;
  logic             restart_pulse;
  logic             error_pulse;
  logic [ERR_W-1:0] error_count;

  modport master (
    output sample_valid, count_in,
    input  locked, direction, step_pulse, wrap_pulse, dir_change_pulse,
           restart_pulse, error_pulse, error_count
  );

  modport slave (
    input  sample_valid, count_in,
    output locked, direction, step_pulse, wrap_pulse, dir_change_pulse,
           restart_pulse, error_pulse, error_count
  );
endinterface

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
//   Observer for a mod-2^WIDTH up/down counter. Each valid sample is compared
//   with the previous one; the difference classifies the move as a legal step
//   (+1/-1), a hold, a restart (jump to zero) or an illegal jump. The block
//   recovers the counting direction, flags wraps/direction changes/restarts/
//   errors as one-cycle pulses and keeps a saturating error tally.
//   Ports:
//     clock   - rising-edge clock
//     clear_n - asynchronous active-low reset
//     bus     - slave side of count_sequence_monitor_if (sample in, status out)
//   All outputs come straight from flops, one cycle after the sampling edge.
//   WIDTH/ERR_W must match the parameters of the connected interface.
module count_sequence_monitor #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clock,
  input  logic                     clear_n,
  count_sequence_monitor_if.slave  bus
);

  // EMPTY: no reference sample yet; PRIMED: reference held, direction unknown;
  // LOCKED: last step was legal and direction is known.
  localparam logic [1:0] ST_EMPTY  = 2'b00;
  localparam logic [1:0] ST_PRIMED = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             direction_q, direction_d;
  logic             locked_q, locked_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             dir_change_q, dir_change_d;
  logic             restart_q, restart_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] error_count_q, error_count_d;

  logic [WIDTH-1:0] delta_s;
  logic             is_up_s;
  logic             is_down_s;
  logic             is_hold_s;
  logic             is_zero_s;
  logic             wraps_s;

  // Classify the current sample against the previous one.
  always_comb begin
    delta_s   = bus.count_in - prev_q;
    is_up_s   = (delta_s == WIDTH'(1));
    // With WIDTH=1 the up and down deltas are the same value; up wins.
    is_down_s = (delta_s == {WIDTH{1'b1}}) && !is_up_s;
    is_hold_s = (delta_s == {WIDTH{1'b0}});
    is_zero_s = (bus.count_in == {WIDTH{1'b0}});
    wraps_s   = (is_up_s && is_zero_s) ||
                (is_down_s && (bus.count_in == {WIDTH{1'b1}}));
  end

  // Next-state, pulse and error-tally logic.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    direction_d   = direction_q;
    step_d        = 1'b0;
    wrap_d        = 1'b0;
    dir_change_d  = 1'b0;
    restart_d     = 1'b0;
    error_d       = 1'b0;
    error_count_d = error_count_q;

    if (bus.sample_valid) begin
      prev_d = bus.count_in;
      case (state_q)
        ST_EMPTY: begin
          state_d = ST_PRIMED;
        end
        ST_PRIMED, ST_LOCKED: begin
          if (is_up_s || is_down_s) begin
            state_d      = ST_LOCKED;
            step_d       = 1'b1;
            wrap_d       = wraps_s;
            // A direction change only exists relative to an established lock.
            dir_change_d = (state_q == ST_LOCKED) && (direction_q != is_up_s);
            direction_d  = is_up_s;
          end else if (is_hold_s) begin
            state_d = state_q;
          end else if (is_zero_s) begin
            restart_d = 1'b1;
            state_d   = ST_PRIMED;
          end else begin
            error_d = 1'b1;
            state_d = ST_PRIMED;
            if (error_count_q != {ERR_W{1'b1}}) begin
              error_count_d = error_count_q + ERR_W'(1);
            end else begin
              error_count_d = error_count_q;
            end
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean restart of acquisition.
          state_d = ST_EMPTY;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Registered copy of the state decode so locked comes directly off a flop.
    locked_d = (state_d == ST_LOCKED);
  end

  // State, reference sample and output registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= ST_EMPTY;
      prev_q        <= {WIDTH{1'b0}};
      direction_q   <= 1'b1;
      locked_q      <= 1'b0;
      step_q        <= 1'b0;
      wrap_q        <= 1'b0;
      dir_change_q  <= 1'b0;
      restart_q     <= 1'b0;
      error_q       <= 1'b0;
      error_count_q <= {ERR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      direction_q   <= direction_d;
      locked_q      <= locked_d;
      step_q        <= step_d;
      wrap_q        <= wrap_d;
      dir_change_q  <= dir_change_d;
      restart_q     <= restart_d;
      error_q       <= error_d;
      error_count_q <= error_count_d;
    end
  end

  assign bus.locked           = locked_q;
  assign bus.direction        = direction_q;
  assign bus.step_pulse       = step_q;
  assign bus.wrap_pulse       = wrap_q;
  assign bus.dir_change_pulse = dir_change_q;
  assign bus.restart_pulse    = restart_q;
  assign bus.error_pulse      = error_q;
  assign bus.error_count      = error_count_q;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Testbench for count_sequence_monitor: directed scenarios with fixed
// expectations, then randomized samples checked against a behavioural model.
module tb_count_sequence_monitor;
  localparam int WIDTH   = 4;
  localparam int ERR_W   = 8;
  localparam int MODV    = 1 << WIDTH;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clock;
  logic clear_n;
  int   n_cmp;
  int   n_err;

  count_sequence_monitor_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  count_sequence_monitor #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: "have a reference", "locked", direction, previous value.
  bit m_have_prev, m_locked, m_dir;
  bit m_step, m_wrap, m_dc, m_restart, m_error;
  int m_prev, m_errcnt;

  function automatic void model_reset();
    m_have_prev = 0; m_locked = 0; m_dir = 1; m_prev = 0; m_errcnt = 0;
    m_step = 0; m_wrap = 0; m_dc = 0; m_restart = 0; m_error = 0;
  endfunction

  function automatic void model_sample(input bit v, input int c);
    int d;
    bit up;
    m_step = 0; m_wrap = 0; m_dc = 0; m_restart = 0; m_error = 0;
    if (!v) return;
    d = (((c - m_prev) % MODV) + MODV) % MODV;
    if (!m_have_prev) begin
      m_have_prev = 1;
    end else if (d == 1 || d == MODV - 1) begin
      up = (d == 1);
      m_step = 1;
      m_wrap = up ? (c == 0) : (c == MODV - 1);
      m_dc = m_locked && (up != m_dir);
      m_dir = up;
      m_locked = 1;
    end else if (d == 0) begin
      // hold
    end else if (c == 0) begin
      m_restart = 1; m_locked = 0;
    end else begin
      m_error = 1; m_locked = 0;
      if (m_errcnt < ERR_MAX) m_errcnt++;
    end
    m_prev = c;
  endfunction

  task automatic send(input bit v, input int c);
    @(negedge clock);
    bus.sample_valid = v;
    bus.count_in = c[WIDTH-1:0];
    @(posedge clock);
    #1;
    model_sample(v, c);
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.count_in = '0;
    model_reset();
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (bus.locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0b want 0", bus.locked); end
    n_cmp++; if (bus.direction !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %0b want 1", bus.direction); end
    n_cmp++; if ({bus.step_pulse, bus.wrap_pulse, bus.dir_change_pulse, bus.restart_pulse, bus.error_pulse} !== 5'b0)
      begin n_err++; $display("FAIL reset_pulses: got %b want 00000", {bus.step_pulse, bus.wrap_pulse, bus.dir_change_pulse, bus.restart_pulse, bus.error_pulse}); end
    n_cmp++; if (bus.error_count !== 8'd0) begin n_err++; $display("FAIL reset_errcnt: got %0d want 0", bus.error_count); end
  endtask

  task automatic test_up_steps();
    do_reset();
    send(1, 3);
    n_cmp++; if ({bus.locked, bus.step_pulse} !== 2'b00) begin n_err++; $display("FAIL first_sample: locked,step=%b want 00", {bus.locked, bus.step_pulse}); end
    send(1, 4);
    n_cmp++; if ({bus.locked, bus.direction, bus.step_pulse} !== 3'b111) begin n_err++; $display("FAIL lock_up: locked,dir,step=%b want 111", {bus.locked, bus.direction, bus.step_pulse}); end
    send(1, 5);
    n_cmp++; if ({bus.step_pulse, bus.wrap_pulse, bus.dir_change_pulse, bus.restart_pulse, bus.error_pulse} !== 5'b10000)
      begin n_err++; $display("FAIL step_up: pulses=%b want 10000", {bus.step_pulse, bus.wrap_pulse, bus.dir_change_pulse, bus.restart_pulse, bus.error_pulse}); end
  endtask

  task automatic test_wrap_reverse();
    do_reset();
    send(1, 13);
    send(1, 14);
    n_cmp++; if (bus.wrap_pulse !== 1'b0) begin n_err++; $display("FAIL wrap_14: got %0b want 0", bus.wrap_pulse); end
    send(1, 15);
    n_cmp++; if (bus.wrap_pulse !== 1'b0) begin n_err++; $display("FAIL wrap_15: got %0b want 0", bus.wrap_pulse); end
    send(1, 0);
    n_cmp++; if ({bus.wrap_pulse, bus.step_pulse, bus.direction, bus.restart_pulse} !== 4'b1110) begin n_err++; $display("FAIL wrap_up: wrap,step,dir,restart=%b want 1110", {bus.wrap_pulse, bus.step_pulse, bus.direction, bus.restart_pulse}); end
    send(1, 0);
    n_cmp++; if ({bus.step_pulse, bus.restart_pulse, bus.locked} !== 3'b001) begin n_err++; $display("FAIL hold_zero: step,restart,locked=%b want 001", {bus.step_pulse, bus.restart_pulse, bus.locked}); end
    send(1, 15);
    n_cmp++; if ({bus.wrap_pulse, bus.dir_change_pulse, bus.direction, bus.step_pulse} !== 4'b1101) begin n_err++; $display("FAIL wrap_down: wrap,dc,dir,step=%b want 1101", {bus.wrap_pulse, bus.dir_change_pulse, bus.direction, bus.step_pulse}); end
  endtask

  task automatic test_hold();
    do_reset();
    send(1, 6);
    send(1, 7);
    for (int i = 0; i < 3; i++) begin
      send(1, 7);
      n_cmp++; if ({bus.locked, bus.step_pulse, bus.dir_change_pulse, bus.error_pulse, bus.restart_pulse} !== 5'b10000)
        begin n_err++; $display("FAIL hold_%0d: locked,step,dc,err,rst=%b want 10000", i, {bus.locked, bus.step_pulse, bus.dir_change_pulse, bus.error_pulse, bus.restart_pulse}); end
    end
    send(1, 6);
    n_cmp++; if ({bus.step_pulse, bus.dir_change_pulse, bus.direction} !== 3'b110) begin n_err++; $display("FAIL reverse_after_hold: step,dc,dir=%b want 110", {bus.step_pulse, bus.dir_change_pulse, bus.direction}); end
  endtask

  task automatic test_restart();
    do_reset();
    send(1, 8);
    send(1, 9);
    send(1, 0);
    n_cmp++; if ({bus.restart_pulse, bus.locked, bus.error_pulse, bus.step_pulse} !== 4'b1000) begin n_err++; $display("FAIL restart: rst,locked,err,step=%b want 1000", {bus.restart_pulse, bus.locked, bus.error_pulse, bus.step_pulse}); end
    n_cmp++; if (bus.error_count !== 8'd0) begin n_err++; $display("FAIL restart_errcnt: got %0d want 0", bus.error_count); end
    send(1, 1);
    n_cmp++; if ({bus.locked, bus.direction, bus.step_pulse, bus.dir_change_pulse} !== 4'b1110) begin n_err++; $display("FAIL relock: locked,dir,step,dc=%b want 1110", {bus.locked, bus.direction, bus.step_pulse, bus.dir_change_pulse}); end
  endtask

  task automatic test_error_saturation();
    do_reset();
    send(1, 4);
    send(1, 5);
    send(1, 11);
    n_cmp++; if ({bus.error_pulse, bus.locked} !== 2'b10) begin n_err++; $display("FAIL error_jump: err,locked=%b want 10", {bus.error_pulse, bus.locked}); end
    n_cmp++; if (bus.error_count !== 8'd1) begin n_err++; $display("FAIL errcnt_one: got %0d want 1", bus.error_count); end
    for (int i = 1; i < 300; i++) begin
      send(1, (i % 2 == 1) ? 5 : 11);
      if (i == 253) begin
        n_cmp++; if (bus.error_count !== 8'd254) begin n_err++; $display("FAIL errcnt_254: got %0d want 254", bus.error_count); end
      end
    end
    n_cmp++; if (bus.error_count !== 8'd255) begin n_err++; $display("FAIL errcnt_sat: got %0d want 255", bus.error_count); end
    n_cmp++; if (bus.error_pulse !== 1'b1) begin n_err++; $display("FAIL err_pulse_sat: got %0b want 1", bus.error_pulse); end
    @(negedge clock);
    bus.sample_valid = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (bus.error_pulse !== 1'b0) begin n_err++; $display("FAIL idle_clears_pulse: got %0b want 0", bus.error_pulse); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send(1, 2);
    send(1, 9);
    send(1, 10);
    send(1, 11);
    #2;
    clear_n = 1'b0;
    bus.sample_valid = 1'b0;
    model_reset();
    #1;
    n_cmp++; if ({bus.locked, bus.step_pulse, bus.direction} !== 3'b001) begin n_err++; $display("FAIL async_reset: locked,step,dir=%b want 001", {bus.locked, bus.step_pulse, bus.direction}); end
    n_cmp++; if (bus.error_count !== 8'd0) begin n_err++; $display("FAIL async_errcnt: got %0d want 0", bus.error_count); end
    @(negedge clock);
    clear_n = 1'b1;
    send(1, 12);
    n_cmp++; if ({bus.locked, bus.step_pulse, bus.wrap_pulse, bus.dir_change_pulse, bus.restart_pulse, bus.error_pulse} !== 6'b0)
      begin n_err++; $display("FAIL post_reset_first: locked+pulses=%b want 000000", {bus.locked, bus.step_pulse, bus.wrap_pulse, bus.dir_change_pulse, bus.restart_pulse, bus.error_pulse}); end
    send(1, 13);
    n_cmp++; if ({bus.locked, bus.direction} !== 2'b11) begin n_err++; $display("FAIL post_reset_lock: locked,dir=%b want 11", {bus.locked, bus.direction}); end
  endtask

  task automatic test_random();
    int r, c;
    bit v;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(0, 99) >= 8);
      r = $urandom_range(0, 99);
      if (r < 45)      c = (m_prev + 1) % MODV;
      else if (r < 70) c = (m_prev + MODV - 1) % MODV;
      else if (r < 80) c = m_prev;
      else if (r < 88) c = 0;
      else             c = $urandom_range(0, MODV - 1);
      send(v, c);
      n_cmp++; if (bus.locked !== m_locked) begin n_err++; $display("FAIL rnd_locked[%0d]: got %0b want %0b", i, bus.locked, m_locked); end
      n_cmp++; if (bus.direction !== m_dir) begin n_err++; $display("FAIL rnd_dir[%0d]: got %0b want %0b", i, bus.direction, m_dir); end
      n_cmp++; if (bus.step_pulse !== m_step) begin n_err++; $display("FAIL rnd_step[%0d]: got %0b want %0b", i, bus.step_pulse, m_step); end
      n_cmp++; if (bus.wrap_pulse !== m_wrap) begin n_err++; $display("FAIL rnd_wrap[%0d]: got %0b want %0b", i, bus.wrap_pulse, m_wrap); end
      n_cmp++; if (bus.dir_change_pulse !== m_dc) begin n_err++; $display("FAIL rnd_dc[%0d]: got %0b want %0b", i, bus.dir_change_pulse, m_dc); end
      n_cmp++; if (bus.restart_pulse !== m_restart) begin n_err++; $display("FAIL rnd_restart[%0d]: got %0b want %0b", i, bus.restart_pulse, m_restart); end
      n_cmp++; if (bus.error_pulse !== m_error) begin n_err++; $display("FAIL rnd_error[%0d]: got %0b want %0b", i, bus.error_pulse, m_error); end
      n_cmp++; if (int'(bus.error_count) != m_errcnt) begin n_err++; $display("FAIL rnd_errcnt[%0d]: got %0d want %0d", i, bus.error_count, m_errcnt); end
    end
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.count_in = '0;
    model_reset();
    test_reset();
    test_up_steps();
    test_wrap_reverse();
    test_hold();
    test_restart();
    test_error_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/count_sequence_monitor.md
Name: count_sequence_monitor

Overview:
Receive-side companion to the mod-2^WIDTH up/down ripple counters. It samples a counter's output bus, recovers the count direction (the counter's enable), flags wrap-arounds, restarts and illegal jumps, and keeps a saturating error tally. It sits beside a counter under test, or at the far end of a count bus, as a self-checking observer.

Parameters:
WIDTH, 4, width of the observed count bus (modulus 2^WIDTH).
ERR_W, 8, width of the saturating error counter.

Ports:
clock  input  1  rising-edge clock.
clear_n  input  1  asynchronous active-low reset.
sample_valid  input  1  count_in is sampled on this cycle.
count_in  input  WIDTH  observed counter value.
locked  output  1  direction is known and the last step was legal.
direction  output  1  1 = up, 0 = down; meaningful only while locked=1.
step_pulse  output  1  one-cycle pulse: a legal +1 or -1 step was accepted.
wrap_pulse  output  1  one-cycle pulse: legal step MAX->0 (up) or 0->MAX (down).
dir_change_pulse  output  1  one-cycle pulse: legal step opposite to the held direction.
restart_pulse  output  1  one-cycle pulse: a non-adjacent jump to 0 was seen (counter clear).
error_pulse  output  1  one-cycle pulse: illegal jump.
error_count  output  ERR_W  total illegal jumps, saturating at 2^ERR_W-1.

Behaviour:
- Reset (clear_n=0, asynchronous): state=EMPTY, prev=0, all pulses=0, locked=0, direction=1, error_count=0. Reset mid-operation discards prev and direction immediately.
- All outputs are registered. Responses appear on the clock edge that samples sample_valid=1 and are visible in the following cycle (1-cycle latency). Pulses last exactly one cycle. Cycles with sample_valid=0 change nothing and force all pulses to 0.
- delta = (count_in - prev) mod 2^WIDTH. UP: delta=1. DOWN: delta=2^WIDTH-1. HOLD: delta=0. RESTART: count_in=0 and not UP/DOWN. ERROR: any other value.
- FSM states are EMPTY, PRIMED and LOCKED. prev<=count_in on every valid sample, in every state.
- EMPTY, valid sample: go to PRIMED. No pulses.
- PRIMED:
  - UP or DOWN: go to LOCKED, direction set to that step, step_pulse=1, wrap_pulse if the step wraps.
  - HOLD: stay in PRIMED.
  - RESTART: restart_pulse=1, stay in PRIMED.
  - ERROR: error_pulse=1, stay in PRIMED.
- LOCKED:
  - UP or DOWN: step_pulse=1. If the step is opposite to direction, dir_change_pulse=1 and direction is updated. wrap_pulse if the step wraps.
  - HOLD: no pulses, stay in LOCKED.
  - RESTART: restart_pulse=1, go to PRIMED, locked=0.
  - ERROR: error_pulse=1, go to PRIMED, locked=0.
- locked=1 exactly when state=LOCKED.
- error_count increments on each error_pulse and holds at all-ones. RESTART does not increment it.
- Priority: UP/DOWN is tested before RESTART. For WIDTH=4, 1->0 is a DOWN step and 15->0 is an UP wrap; neither is a restart.
- For WIDTH=1, UP and DOWN coincide (delta=1). Treat delta=1 as UP.

Test Plan:
- Reset, then valid samples 3,4,5 -> after 4: locked=1, direction=1, step_pulse=1. After 5: step_pulse=1, no other pulses.
- Locked up, samples 14,15,0 -> wrap_pulse=1 on 0 only, direction stays 1. Then samples 0,15 (down) -> wrap_pulse=1 and dir_change_pulse=1 on 15, direction=0.
- Locked at 7, sample 7 repeated 3x, then 6 -> no pulses during the holds, then step_pulse=1, dir_change_pulse=1, direction=0.
- Locked at 9, sample 0 -> restart_pulse=1, locked=0, error_count unchanged. Then sample 1 -> locked=1, direction=1.
- Locked at 5, sample 11 -> error_pulse=1, locked=0, error_count=1. Force 300 errors with ERR_W=8 -> error_count holds at 255.
- Assert clear_n low mid-stream between clock edges -> outputs reach reset values without a clock edge. After release, the first sample produces no pulses and locked=0.
